// File: rtl/fft_pkg.sv
// Shared definitions for FFT-stage resources: datapath defaults, the complex-multiply
// scheduler FSM encoding and the issue order of the four real partial products.
package fft_pkg;

  localparam int unsigned W_DEF       = 32;
  localparam int unsigned FRAC_DEF    = 16;
  localparam int unsigned MUL_LAT_DEF = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef logic [1:0] prod_idx_t;

  // Issue order; the accumulator relies on real-part products coming first.
  localparam prod_idx_t PROD_AR_BR = 2'd0;
  localparam prod_idx_t PROD_AI_BI = 2'd1;
  localparam prod_idx_t PROD_AR_BI = 2'd2;
  localparam prod_idx_t PROD_AI_BR = 2'd3;
  localparam prod_idx_t PROD_LAST  = PROD_AI_BR;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps; grant is one-hot and only
// asserted while enabled.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      cand = sum[IDW-1:0];
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/cmult_share_sched.sv
// Shares one pipelined fixed-point real multiplier among NREQ complex-product requesters:
// round-robin grant, four back-to-back partial products, accumulate, tagged result.
module cmult_share_sched
  import fft_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned FRAC    = FRAC_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  localparam int unsigned IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_ar,
  input  logic [NREQ*W-1:0] req_ai,
  input  logic [NREQ*W-1:0] req_br,
  input  logic [NREQ*W-1:0] req_bi,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_re,
  output logic [W-1:0]      res_im,
  output logic              busy
);

  state_e         state_q, state_d;
  prod_idx_t      k_q;
  logic [IDW-1:0] ptr_q, id_q;
  logic [W-1:0]   ar_q, ai_q, br_q, bi_q;
  logic [W-1:0]   re_q, im_q;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            arb_en;
  logic            hs;

  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] a_ext, b_ext;
  logic [W-1:0]   mul_trunc;
  logic           mul_vld;

  logic [W-1:0] pipe_p [MUL_LAT];
  logic         pipe_v [MUL_LAT];
  prod_idx_t    pipe_k [MUL_LAT];
  logic         out_v;
  prod_idx_t    out_k;
  logic [W-1:0] out_p;
  logic         p3_done;

  // Grant is masked during reset so req_ready reads 0 while rst is low.
  assign arb_en = (state_q == StIdle) && rst;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign hs = |gnt;

  // ---------------------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs) state_d = StIssue;
      StIssue: if (k_q == PROD_LAST) state_d = StDrain;
      StDrain: if (p3_done) state_d = StDone;
      StDone:  if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = gnt;
    res_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    mul_vld   = (state_q == StIssue);
  end

  assign res_id = id_q;
  assign res_re = re_q;
  assign res_im = im_q;

  // ---------------------------------------------------------------------------------------
  // Operand latch, pointer and issue counter
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      id_q  <= '0;
      ar_q  <= '0;
      ai_q  <= '0;
      br_q  <= '0;
      bi_q  <= '0;
      k_q   <= PROD_AR_BR;
    end else begin
      if (hs) begin
        ar_q  <= req_ar[32'(gnt_idx) * W +: W];
        ai_q  <= req_ai[32'(gnt_idx) * W +: W];
        br_q  <= req_br[32'(gnt_idx) * W +: W];
        bi_q  <= req_bi[32'(gnt_idx) * W +: W];
        id_q  <= gnt_idx;
        ptr_q <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
      k_q <= (state_q == StIssue) ? k_q + 2'd1 : PROD_AR_BR;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Shared multiplier: operand select and MUL_LAT-deep pipeline
  // ---------------------------------------------------------------------------------------
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (k_q)
      PROD_AR_BR: begin mul_a = ar_q; mul_b = br_q; end
      PROD_AI_BI: begin mul_a = ai_q; mul_b = bi_q; end
      PROD_AR_BI: begin mul_a = ar_q; mul_b = bi_q; end
      PROD_AI_BR: begin mul_a = ai_q; mul_b = br_q; end
      default:    begin mul_a = '0;   mul_b = '0;   end
    endcase
  end

  // Sign-extended operands make the low 2W bits of the product the signed result;
  // the right shift then floors toward minus infinity.
  assign a_ext     = {{W{mul_a[W-1]}}, mul_a};
  assign b_ext     = {{W{mul_b[W-1]}}, mul_b};
  assign mul_trunc = W'((a_ext * b_ext) >> FRAC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        pipe_p[i] <= '0;
        pipe_v[i] <= 1'b0;
        pipe_k[i] <= PROD_AR_BR;
      end
    end else begin
      pipe_p[0] <= mul_trunc;
      pipe_v[0] <= mul_vld;
      pipe_k[0] <= k_q;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        pipe_p[i] <= pipe_p[i-1];
        pipe_v[i] <= pipe_v[i-1];
        pipe_k[i] <= pipe_k[i-1];
      end
    end
  end

  assign out_v   = pipe_v[MUL_LAT-1];
  assign out_k   = pipe_k[MUL_LAT-1];
  assign out_p   = pipe_p[MUL_LAT-1];
  assign p3_done = out_v && (out_k == PROD_LAST);

  // ---------------------------------------------------------------------------------------
  // Accumulators (wrap modulo 2^W)
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      re_q <= '0;
      im_q <= '0;
    end else if (out_v) begin
      unique case (out_k)
        PROD_AR_BR: re_q <= out_p;
        PROD_AI_BI: re_q <= re_q - out_p;
        PROD_AR_BI: im_q <= out_p;
        PROD_AI_BR: im_q <= im_q + out_p;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmult_share_sched.sv
// Directed + randomized bench for cmult_share_sched against a complex-arithmetic model.
module tb_cmult_share_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int FRAC = 16;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_ar, req_ai, req_br, req_bi;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_id;
  logic [W-1:0]      res_re, res_im;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          model_ptr = 0;
  logic [31:0] exp_re, exp_im;
  int          exp_id;

  cmult_share_sched #(
    .NREQ    (NREQ),
    .W       (W),
    .FRAC    (FRAC),
    .MUL_LAT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ar    (req_ar),
    .req_ai    (req_ai),
    .req_br    (req_br),
    .req_bi    (req_bi),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_re    (res_re),
    .res_im    (res_im),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fixed-point real product, floored, wrapped to 32 bits.
  function automatic logic [31:0] fx_mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    longint q;
    p = longint'($signed(x)) * longint'($signed(y));
    q = p >>> FRAC;
    return q[31:0];
  endfunction

  // (ar + j ai) * (br + j bi)
  task automatic cmodel(input logic [31:0] ar, ai, br, bi, output logic [31:0] re, im);
    re = fx_mul(ar, br) - fx_mul(ai, bi);
    im = fx_mul(ar, bi) + fx_mul(ai, br);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v);
    for (int j = 0; j < NREQ; j++) begin
      int c;
      c = (model_ptr + j) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic apply_req(input int i, input logic [31:0] ar, ai, br, bi);
    req_ar[i*W +: W] = ar;
    req_ai[i*W +: W] = ai;
    req_br[i*W +: W] = br;
    req_bi[i*W +: W] = bi;
    req_valid[i]     = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_id"},    res_id,    0);
    chk({tag, "_res_re"},    res_re,    0);
    chk({tag, "_res_im"},    res_im,    0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  // Present a request and wait (bounded) for its grant; leaves the bench at the grant cycle.
  task automatic start_and_grant(input int i, input logic [31:0] ar, ai, br, bi,
                                 input string tag, output bit ok);
    int pick;
    logic [NREQ-1:0] exp_vec;
    apply_req(i, ar, ai, br, bi);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_granted"}, {63'b0, ok}, 1);
    if (!ok) return;
    pick    = rr_pick(req_valid);
    exp_vec = (pick < 0) ? '0 : NREQ'(1) << pick;
    chk({tag, "_gnt"}, req_ready, exp_vec);
    model_ptr = (i + 1) % NREQ;
    cmodel(ar, ai, br, bi, exp_re, exp_im);
    exp_id = i;
  endtask

  task automatic wait_result(input string tag);
    int k;
    k = 1;
    #1;
    while (!res_valid && k < 30) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_latency"}, k, 7);
    chk({tag, "_id"}, res_id, exp_id);
    chk({tag, "_re"}, res_re, exp_re);
    chk({tag, "_im"}, res_im, exp_im);
  endtask

  task automatic finish_job(input int i, input string tag);
    @(negedge clk);
    req_valid[i]     = 1'b0;
    req_ar[i*W +: W] = $urandom;  // post-handshake changes must not matter
    req_bi[i*W +: W] = $urandom;
    wait_result(tag);
    if (res_ready) begin
      @(negedge clk);
      #1;
      chk({tag, "_drop"}, res_valid, 0);
    end
  endtask

  task automatic run_single(input int i, input logic [31:0] ar, ai, br, bi, input string tag,
                            input bit fixed = 1'b0, input logic [31:0] fre = '0,
                            input logic [31:0] fim = '0);
    bit ok;
    start_and_grant(i, ar, ai, br, bi, tag, ok);
    if (!ok) return;
    if (fixed) begin
      exp_re = fre;
      exp_im = fim;
    end
    finish_job(i, tag);
  endtask

  initial begin
    logic [31:0] eq_re[$], eq_im[$];
    int          eq_id[$];
    int          order[6];
    int          hs_n, res_n, last_hs, pend, w;
    bit          stop, ok, saw;
    logic [31:0] op[4];

    order     = '{0, 1, 2, 3, 0, 1};
    rst       = 1'b0;
    req_valid = '0;
    req_ar    = '0;
    req_ai    = '0;
    req_br    = '0;
    req_bi    = '0;
    res_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Round-robin fairness with all requesters valid
    for (int i = 0; i < NREQ; i++) apply_req(i, $urandom, $urandom, $urandom, $urandom);
    hs_n = 0; res_n = 0; last_hs = -1; pend = -1; stop = 1'b0;
    for (int t = 0; t < 200 && res_n < 6; t++) begin
      if (pend >= 0) begin
        if (stop) req_valid = '0;
        else apply_req(pend, $urandom, $urandom, $urandom, $urandom);
        pend = -1;
      end
      #1;
      if (res_valid) begin
        if (eq_id.size() == 0) begin
          chk("rr_spurious_res", res_valid, 0);
        end else begin
          chk("rr_res_id", res_id, eq_id.pop_front());
          chk("rr_res_re", res_re, eq_re.pop_front());
          chk("rr_res_im", res_im, eq_im.pop_front());
        end
        res_n++;
      end
      if (|(req_valid & req_ready)) begin
        w = -1;
        for (int j = NREQ - 1; j >= 0; j--) if (req_ready[j]) w = j;
        chk("rr_gnt", req_ready, NREQ'(1) << rr_pick(req_valid));
        if (hs_n < 6) chk("rr_order", w, order[hs_n]);
        if (last_hs >= 0) chk("rr_interval", cyc - last_hs, 8);
        last_hs = cyc;
        cmodel(req_ar[w*W +: W], req_ai[w*W +: W], req_br[w*W +: W], req_bi[w*W +: W],
               exp_re, exp_im);
        eq_re.push_back(exp_re);
        eq_im.push_back(exp_im);
        eq_id.push_back(w);
        model_ptr = (w + 1) % NREQ;
        hs_n++;
        pend = w;
        if (hs_n == 6) stop = 1'b1;
      end
      @(negedge clk);
    end
    chk("rr_results", res_n, 6);
    req_valid = '0;
    repeat (2) @(negedge clk);

    // Directed single-request cases
    run_single(2, 32'h0001_8000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000, "single",
               1'b1, 32'h0002_C000, 32'hFFFF_8000);
    run_single(0, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, "trunc",
               1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_single(3, 32'h00C8_0000, 32'h0000_0000, 32'h00C8_0000, 32'h0000_0000, "wrap",
               1'b1, 32'h9C40_0000, 32'h0000_0000);

    // Back-pressure: hold res_ready low with requester 1 waiting
    res_ready = 1'b0;
    start_and_grant(0, $urandom, $urandom, $urandom, $urandom, "bp0", ok);
    if (ok) begin
      for (int j = 0; j < 4; j++) op[j] = $urandom;
      @(negedge clk);
      req_valid[0] = 1'b0;
      apply_req(1, op[0], op[1], op[2], op[3]);
      wait_result("bp0");
      for (int j = 0; j < 5; j++) begin
        chk("bp_hold_valid", res_valid, 1);
        chk("bp_hold_re", res_re, exp_re);
        chk("bp_hold_im", res_im, exp_im);
        chk("bp_hold_id", res_id, 0);
        chk("bp_hold_ready", req_ready, 0);
        @(negedge clk);
        #1;
      end
      res_ready = 1'b1;
      #1;
      chk("bp_release_valid", res_valid, 1);
      @(negedge clk);
      #1;
      chk("bp_next_gnt", req_ready, 4'b0010);
      run_single(1, op[0], op[1], op[2], op[3], "bp1");
    end

    // Reset during ISSUE k=2 on requester 1, then show the pointer returned to 0
    start_and_grant(1, $urandom, $urandom, $urandom, $urandom, "rst_job", ok);
    if (ok) begin
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      model_ptr = 0;
      @(negedge clk);
      rst = 1'b1;
      saw = 1'b0;
      for (int j = 0; j < 12; j++) begin
        #1;
        saw = saw | res_valid;
        @(negedge clk);
      end
      chk("rst_no_stale", {63'b0, saw}, 0);
      for (int j = 0; j < 4; j++) op[j] = $urandom;
      apply_req(2, op[0], op[1], op[2], op[3]);
      run_single(0, $urandom, $urandom, $urandom, $urandom, "post_rst");
      run_single(2, op[0], op[1], op[2], op[3], "post_rst2");
    end

    // Randomized single requests
    for (int r = 0; r < 8; r++) begin
      run_single($urandom_range(0, NREQ - 1), $urandom, $urandom, $urandom, $urandom, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmult_share_sched.md
Name: cmult_share_sched

Overview:
- Shares one pipelined signed fixed-point real multiplier between NREQ butterfly requesters that need complex twiddle products.
- Arbitrates round-robin and latches the granted operands.
- Issues the 4 real partial products back-to-back, then combines them (re = ar·br − ai·bi, im = ar·bi + ai·br).
- Returns the result tagged with the requester id. Sits between the FFT stage butterflies and the multiplier resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand/result width, signed two's complement.
- FRAC, 16, fractional bits (Q(W−FRAC).FRAC).
- MUL_LAT, 2, internal multiplier pipeline depth in cycles (≥1).

Ports:
- clk, input, 1, rising-edge clock for all state.
- rst, input, 1, reset, asynchronous, active-low.
- req_valid, input, NREQ, per-requester request valid.
- req_ready, output, NREQ, one-hot grant/accept; handshake when valid & ready.
- req_ar, input, NREQ·W, operand A real, requester i at bits [i·W +: W].
- req_ai, input, NREQ·W, operand A imaginary, same packing.
- req_br, input, NREQ·W, operand B (twiddle) real, same packing.
- req_bi, input, NREQ·W, operand B imaginary, same packing.
- res_valid, output, 1, result valid.
- res_ready, input, 1, consumer accept.
- res_id, output, clog2(NREQ), index of the requester that owns the result.
- res_re, output, W, result real.
- res_im, output, W, result imaginary.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (rst low, async): FSM = IDLE, rr pointer = 0, accumulators = 0, multiplier pipe cleared.
  - Outputs during reset: res_valid = 0, res_id = 0, res_re = 0, res_im = 0, req_ready = 0, busy = 0.
  - Reset mid-operation discards the in-flight job; no result is produced for it.
- FSM IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE:
  - req_ready is combinational: one-hot on the winner of the rr search, only while in IDLE.
  - Search starts at the rr pointer and wraps from NREQ−1 to 0.
  - On handshake: latch operands and id, set pointer = (winner+1) mod NREQ, go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE: 4 cycles, k = 0..3, presenting to the multiplier in this order:
  - k=0: ar·br
  - k=1: ai·bi
  - k=2: ar·bi
  - k=3: ai·br
  - Then go to DRAIN.
- Multiplier:
  - Full signed 2W-bit product; result = product[W+FRAC−1:FRAC]. This is arithmetic truncation (floor), no rounding.
  - Output is visible MUL_LAT cycles after its inputs are presented; one new input per cycle.
- Accumulate on return:
  - P0 loads re.
  - P1 subtracts from re.
  - P2 loads im.
  - P3 adds to im.
  - All additions wrap modulo 2^W; no saturation.
- DRAIN: wait until P3 has been accumulated, then go to DONE.
- DONE:
  - res_valid = 1; res_id, res_re and res_im stay stable until res_ready.
  - On res_valid & res_ready: go to IDLE.
  - A new grant is possible in that same next IDLE cycle.
- Latency with MUL_LAT = 2: request handshake in cycle c0 → res_valid first high in c0+7 (generally 5+MUL_LAT).
  - Throughput: one complex product per 6+MUL_LAT cycles with res_ready held high.
- Request rules: a requester holds valid and operands stable until ready. Operand changes after the handshake have no effect.
- Simultaneous events:
  - res_ready with no res_valid: ignored.
  - Requests arriving while busy: wait; req_ready stays 0.

Decomposition:
- Shared package fft_pkg:
  - W, FRAC and MUL_LAT defaults.
  - FSM state encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3).
  - The product-index constants for the 4 real products.
- One sub-module: rr_arbiter (NREQ; inputs req, pointer, enable; outputs one-hot grant and encoded index). It is reusable for other shared FFT resources.

Test Plan:
- Single request, id 2:
  - Stimulus: a = 0x00018000 + j0x00020000 (1.5+2j); b = 0x00008000 + j0xFFFF0000 (0.5−1j); res_ready = 1.
  - Required: res_valid exactly 7 cycles after handshake; res_re = 0x0002C000 (2.75), res_im = 0xFFFF8000 (−0.5), res_id = 2.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously.
  - Required: grant order 0,1,2,3,0,1; successive handshakes exactly 8 cycles apart.
- Truncation:
  - Stimulus: a = 0xFFFF0000 + j0 (−1); b = 0x00000001 + j0.
  - Required: res_re = 0xFFFFFFFF (floor of −2^−16 scaled), res_im = 0xFFFFFFFF (floor of −2^−16, from P2 = ar·bi).
- Wrap:
  - Stimulus: a = 0x00C80000 (200) real only; b = 0x00C80000.
  - Required: res_re = 0x9C400000 (wrapped), res_im = 0.
- Back-pressure:
  - Stimulus: res_ready held 0 for 5 cycles after res_valid rises, with requester 1 valid.
  - Required: res outputs stable, req_ready = 0 throughout; requester 1 granted the cycle after res_ready = 1.
- Reset mid-ISSUE:
  - Stimulus: assert rst low during ISSUE k=2, then release.
  - Required: all outputs 0 immediately; no stale res_valid; next request returns a correct result at +7 cycles.
